// File: rtl/auto_guesser.sv
// rtl/auto_guesser.sv - binary-search player driving the number-guessing game
module auto_guesser #(
    parameter int WIDTH    = 8,
    parameter int RESP_LAT = 2,
    parameter int TRY_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dp_over,
    input  logic             dp_under,
    input  logic             dp_equal,
    output logic [WIDTH-1:0] guess,
    output logic             enter,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [WIDTH-1:0] found,
    output logic [TRY_W-1:0] tries
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRESENT, S_WAIT, S_EVAL, S_DONE, S_FAIL
    } state_t;

    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [WIDTH-1:0] ONE      = 1;
    localparam logic [TRY_W-1:0] ONE_T    = 1;
    localparam logic [3:0]       LAT_INIT = 4'(RESP_LAT - 1);

    state_t           state_q, state_n;
    logic [WIDTH-1:0] lo_q, lo_n, hi_q, hi_n;
    logic [3:0]       cnt_q, cnt_n;
    logic [WIDTH-1:0] guess_n, found_n;
    logic [TRY_W-1:0] tries_n;
    logic             enter_n, busy_n, done_n, fail_n;
    logic             launch;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= MAX;
            cnt_q   <= '0;
            guess   <= '0;
            enter   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            found   <= '0;
            tries   <= '0;
        end else begin
            state_q <= state_n;
            lo_q    <= lo_n;
            hi_q    <= hi_n;
            cnt_q   <= cnt_n;
            guess   <= guess_n;
            enter   <= enter_n;
            busy    <= busy_n;
            done    <= done_n;
            fail    <= fail_n;
            found   <= found_n;
            tries   <= tries_n;
        end
    end

    // Outputs are computed one cycle ahead so guess/enter/tries are valid
    // from the first cycle of PRESENT.
    always_comb begin
        state_n = state_q;
        lo_n    = lo_q;
        hi_n    = hi_q;
        cnt_n   = cnt_q;
        guess_n = guess;
        found_n = found;
        tries_n = tries;
        enter_n = 1'b0;
        launch  = 1'b0;
        sum     = '0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    lo_n    = '0;
                    hi_n    = MAX;
                    tries_n = '0;
                    launch  = 1'b1;
                end
            end
            S_PRESENT: begin
                if (RESP_LAT <= 1) begin
                    state_n = S_EVAL;
                end else begin
                    state_n = S_WAIT;
                    cnt_n   = LAT_INIT;
                end
            end
            S_WAIT: begin
                cnt_n = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_n = S_EVAL;
            end
            S_EVAL: begin
                case ({dp_over, dp_under, dp_equal})
                    3'b001: begin
                        state_n = S_DONE;
                        found_n = guess;
                    end
                    3'b100: begin
                        if (guess == lo_q) begin
                            state_n = S_FAIL;
                        end else begin
                            hi_n   = guess - ONE;
                            launch = 1'b1;
                        end
                    end
                    3'b010: begin
                        if (guess == hi_q) begin
                            state_n = S_FAIL;
                        end else begin
                            lo_n   = guess + ONE;
                            launch = 1'b1;
                        end
                    end
                    default: state_n = S_FAIL;
                endcase
            end
            default: state_n = S_IDLE;
        endcase

        if (launch) begin
            sum     = {1'b0, lo_n} + {1'b0, hi_n};
            guess_n = sum[WIDTH:1];
            enter_n = 1'b1;
            tries_n = tries_n + ONE_T;
            state_n = S_PRESENT;
        end

        busy_n = (state_n == S_PRESENT) || (state_n == S_WAIT) || (state_n == S_EVAL);
        done_n = (state_n == S_DONE);
        fail_n = (state_n == S_FAIL);
    end

endmodule

// File: tb/tb_auto_guesser.sv
// tb/tb_auto_guesser.sv - scoreboard bench for auto_guesser against a game model
module tb_auto_guesser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dp_over, dp_under, dp_equal;
    logic [7:0] guess, found;
    logic       enter, busy, done, fail;
    logic [3:0] tries;

    logic [7:0] actual;
    int         mode;
    logic [7:0] g_lat;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_enter = -1;
    int         sb[$];

    auto_guesser #(.WIDTH(8), .RESP_LAT(2), .TRY_W(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dp_over(dp_over), .dp_under(dp_under), .dp_equal(dp_equal),
        .guess(guess), .enter(enter), .busy(busy), .done(done), .fail(fail),
        .found(found), .tries(tries)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Game: latch the submitted guess, flags are a compare against that latch.
    // mode 0 honest, 1 always "under", 2 both over and under.
    always @(posedge clk or posedge reset) begin
        if (reset) g_lat <= '0;
        else if (enter) g_lat <= guess;
    end
    assign dp_over  = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (g_lat > actual);
    assign dp_under = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b1 : (g_lat < actual);
    assign dp_equal = (mode == 0) && (g_lat == actual);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic gen_expected(input logic [7:0] act, input int md);
        int lo = 0;
        int hi = 255;
        int g;
        for (int k = 0; k < 16; k++) begin
            g = (lo + hi) / 2;
            sb.push_back(g);
            if (md == 2) break;
            if (md == 0 && g == act) break;
            if (md == 0 && g > act) begin
                if (g == lo) break;
                hi = g - 1;
            end else begin
                if (g == hi) break;
                lo = g + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && enter) begin
            if (sb.size() == 0) begin
                check("extra_enter", 1, 0);
            end else begin
                check("guess", guess, sb.pop_front());
            end
            if (last_enter >= 0) check("enter_gap", cyc - last_enter, 3);
            last_enter = cyc;
        end
    end

    task automatic run(input logic [7:0] act, input int md, input bit poke,
                       input bit exp_done, input logic [7:0] exp_found,
                       input logic [3:0] exp_tries);
        last_enter = -1;
        actual = act;
        mode   = md;
        gen_expected(act, md);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done || fail) break;
            if (poke && i == 5) begin
                check("busy_at_poke", busy, 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!(done || fail)) check("timeout", 0, 1);
        check("done", done, exp_done);
        check("fail", fail, !exp_done);
        check("tries", tries, exp_tries);
        if (exp_done) check("found", found, exp_found);
        check("busy_end", busy, 0);
        check("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int n_enter;
        reset  = 1'b1;
        start  = 1'b0;
        actual = '0;
        mode   = 0;
        repeat (3) @(negedge clk);
        check("rst_guess", guess, 0);
        check("rst_enter", enter, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_found", found, 0);
        check("rst_tries", tries, 0);
        reset = 1'b0;
        @(negedge clk);

        run(8'd12,  0, 1'b0, 1'b1, 8'd12,  4'd8);
        run(8'd127, 0, 1'b0, 1'b1, 8'd127, 4'd1);
        run(8'd255, 0, 1'b0, 1'b1, 8'd255, 4'd9);
        run(8'd0,   0, 1'b0, 1'b1, 8'd0,   4'd8);
        run(8'd0,   1, 1'b0, 1'b0, 8'd0,   4'd9);
        run(8'd0,   2, 1'b0, 1'b0, 8'd0,   4'd1);

        // Reset asserted mid-search, during the WAIT after the third guess.
        last_enter = -1;
        actual = 8'd50;
        mode   = 0;
        gen_expected(8'd50, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_enter = 0;
        for (int i = 0; i < 100 && n_enter < 3; i++) begin
            if (enter) n_enter++;
            if (n_enter < 3) @(negedge clk);
        end
        check("third_enter_seen", n_enter, 3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_guess", guess, 0);
        check("async_enter", enter, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_fail", fail, 0);
        check("async_found", found, 0);
        check("async_tries", tries, 0);
        @(negedge clk) reset = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        run(8'd200, 0, 1'b1, 1'b1, 8'd200, 4'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/auto_guesser.md
Name: auto_guesser

Overview:
- Automatic player for the number-guessing game; it drives the game's `guess`/`enter` inputs and consumes its `dp_over`/`dp_under`/`dp_equal` outputs.
- Runs a binary search over the full `WIDTH`-bit range until the game reports equal, then reports the secret value and the number of tries.
- Sits beside the game top in self-play and bring-up configurations; it replaces the switches and pushbutton.

Parameters:
- WIDTH, 8, bit width of guess and search range (0 .. 2^WIDTH-1).
- RESP_LAT, 2, clock cycles from the `enter` pulse to when the game's result flags are valid; range 1..15.
- TRY_W, 4, width of the try counter; must hold WIDTH+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new search; sampled in IDLE, DONE or FAIL.
- dp_over  in  1  from game: last guess greater than actual.
- dp_under  in  1  from game: last guess less than actual.
- dp_equal  in  1  from game: last guess equals actual.
- guess  out  WIDTH  value presented to the game.
- enter  out  1  one-cycle submit strobe to the game.
- busy  out  1  high in PRESENT, WAIT and EVAL.
- done  out  1  high in DONE (search succeeded).
- fail  out  1  high in FAIL (inconsistent or absent response).
- found  out  WIDTH  matched value; valid while done=1.
- tries  out  TRY_W  guesses submitted in the current or last search.

Behaviour:
- Reset (async, any state, including mid-search):
  - state=IDLE.
  - guess, enter, busy, done, fail, found, tries all 0.
  - lo=0, hi=2^WIDTH-1.
- Registers:
  - lo and hi, WIDTH bits each.
  - Latency counter, 4 bits.
  - All outputs are registered.
- Guess arithmetic: guess = (lo+hi)>>1, computed in WIDTH+1 bits so there is no overflow.
- State transitions:
  - IDLE:
    - start=1 → PRESENT; load lo=0, hi=max, tries=0; clear done/fail.
    - start=0 → stay.
  - PRESENT (1 cycle):
    - guess = (lo+hi)>>1; enter=1; tries += 1.
    - → WAIT with counter=RESP_LAT-1.
  - WAIT:
    - enter=0; guess held stable.
    - Counter decrements; at 0 → EVAL.
    - RESP_LAT=1 gives zero WAIT cycles: PRESENT → EVAL directly.
  - EVAL: samples the flags on this cycle's edge; exactly one flag must be high.
    - dp_equal only → DONE; found=guess.
    - dp_over only:
      - guess==lo → FAIL (search space exhausted; this also covers guess==0, so hi never underflows).
      - otherwise hi=guess-1 → PRESENT.
    - dp_under only:
      - guess==hi → FAIL (this also covers guess==max, so lo never overflows).
      - otherwise lo=guess+1 → PRESENT.
    - Zero flags or more than one flag → FAIL.
  - DONE / FAIL:
    - Hold found/tries; guess stays at its last value.
    - start=1 → restart exactly as from IDLE.
- Start handling: start is ignored while busy=1.
- Timing guarantees:
  - guess is stable from the PRESENT cycle through EVAL.
  - enter is never asserted two cycles in a row.
  - Successive enter pulses are spaced RESP_LAT+1 cycles apart.
- Try bound: a correct game finishes in at most WIDTH+1 guesses (9 for WIDTH=8).

Test Plan:
- Model the game as a registered compare against `actual` with RESP_LAT=2.
- actual=8'd12, pulse start → guesses 127,63,31,15,7,11,13,12 → done=1, found=12, tries=8, fail=0.
- actual=8'd127 → single guess 127 → done=1 after one enter, tries=1.
- actual=8'd255 → guesses 127,191,223,239,247,251,253,254,255 → done=1, tries=9.
- actual=8'd0 → guesses 127,63,31,15,7,3,1,0 → done=1, found=0, tries=8, with no hi underflow.
- Responder forces dp_under=1 every time → FAIL after guess 255, tries=9. Separately, dp_over and dp_under both high at the first EVAL → fail=1, tries=1.
- Assert reset during the WAIT of the 3rd guess → all outputs 0 immediately (asynchronous), state IDLE. Then start with actual=8'd200 completes normally; pulsing start while busy=1 has no effect.
